// File: rtl/cmd_decoder_pkg.sv
// Shared command codes, echo FSM encoding and small helpers for cmd_decoder.
package cmd_decoder_pkg;

    localparam logic [7:0] CMD_ON     = 8'hEE;
    localparam logic [7:0] CMD_OFF    = 8'h55;
    localparam logic [7:0] CMD_TOGGLE = 8'hC3;

    localparam int unsigned CLK_FREQ  = 24000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2
    } echo_state_e;

    // True when the byte is one of the three command codes
    function automatic logic is_cmd(input logic [7:0] code);
        return (code == CMD_ON) || (code == CMD_OFF) || (code == CMD_TOGGLE);
    endfunction

    // Increment that sticks at all-ones
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/cmd_decoder_link_watchdog.sv
// Link watchdog: counts cycles while enabled, pulses expire_c after WDT_CYCLES.
module link_watchdog #(
    parameter int unsigned WDT_CYCLES = 240000000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expire_c
);

    localparam int unsigned CW = $clog2(WDT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(WDT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Expiry is flagged on the cycle the count would reach WDT_CYCLES
    assign expire_c = enable && (cnt == LAST);

    // Counter: cleared by command, held at zero while disabled, wraps on expiry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || !enable || expire_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/cmd_decoder.sv
// Command decoder: gate control from main-board bytes, echo to uart_tx, link watchdog.
module cmd_decoder
    import cmd_decoder_pkg::*;
#(
    parameter int unsigned WDT_CYCLES   = 240000000,
    parameter int unsigned ECHO_TIMEOUT = 2400
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_received,
    input  logic       rx_done,
    input  logic       parity_error,
    input  logic       tx_busy,
    output logic [7:0] data_to_tx,
    output logic       start_tx,
    output logic       gate_en,
    output logic       wdt_trip,
    output logic       cmd_err,
    output logic [7:0] err_count
);

    localparam int unsigned TW = $clog2(ECHO_TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(ECHO_TIMEOUT - 1);

    echo_state_e   state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic [7:0]    data_d;
    logic [7:0]    err_count_d;
    logic          start_d, gate_d, trip_d, err_d;
    logic          accept, reject, wdt_expire_c;

    // Parity error wins over decode
    assign accept = rx_done && !parity_error && is_cmd(data_received);
    assign reject = rx_done && !accept;

    link_watchdog #(
        .WDT_CYCLES (WDT_CYCLES)
    ) u_wdt (
        .clk      (clk),
        .reset    (reset),
        .enable   (gate_en),
        .clear    (accept),
        .expire_c (wdt_expire_c)
    );

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            timer      <= '0;
            start_tx   <= 1'b0;
            data_to_tx <= 8'h00;
            gate_en    <= 1'b0;
            wdt_trip   <= 1'b0;
            cmd_err    <= 1'b0;
            err_count  <= 8'h00;
        end else begin
            state      <= state_d;
            timer      <= timer_d;
            start_tx   <= start_d;
            data_to_tx <= data_d;
            gate_en    <= gate_d;
            wdt_trip   <= trip_d;
            cmd_err    <= err_d;
            err_count  <= err_count_d;
        end
    end

    // Next state: gate/watchdog update, echo handshake, error pulse
    always_comb begin
        state_d     = state;
        timer_d     = timer;
        start_d     = start_tx;
        data_d      = data_to_tx;
        gate_d      = gate_en;
        trip_d      = wdt_trip;
        err_d       = reject;

        // A command in the expiry cycle takes priority over the trip
        if (accept) begin
            case (data_received)
                CMD_ON:  gate_d = 1'b1;
                CMD_OFF: gate_d = 1'b0;
                default: gate_d = ~gate_en;
            endcase
            trip_d = 1'b0;
        end else if (wdt_expire_c) begin
            gate_d = 1'b0;
            trip_d = 1'b1;
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    state_d = REQ;
                    start_d = 1'b1;
                    data_d  = data_received;
                    timer_d = '0;
                end
            end
            REQ: begin
                if (accept) begin
                    err_d = 1'b1;
                end
                if (tx_busy) begin
                    start_d = 1'b0;
                    state_d = BUSY;
                end else if (timer == TLAST) begin
                    start_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            BUSY: begin
                if (accept) begin
                    err_d = 1'b1;
                end
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                start_d = 1'b0;
            end
        endcase

        err_count_d = err_d ? sat_inc(err_count) : err_count;
    end

endmodule

// File: tb/tb_cmd_decoder.sv
// Bench for cmd_decoder: directed scenarios plus random traffic against a behavioural model.
module tb_cmd_decoder;

    localparam int unsigned WDT = 100;
    localparam int unsigned TO  = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_received = 8'h00;
    logic       rx_done = 1'b0;
    logic       parity_error = 1'b0;
    logic       tx_busy = 1'b0;
    logic [7:0] data_to_tx;
    logic       start_tx;
    logic       gate_en;
    logic       wdt_trip;
    logic       cmd_err;
    logic [7:0] err_count;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Behavioural model state
    int unsigned m_gate, m_trip, m_start, m_err, m_errcnt;
    logic [7:0]  m_data;
    int unsigned on_cycles;   // cycles gate has been on since last clear
    int unsigned echo_mode;   // 0 no echo, 1 waiting for uart, 2 uart sending
    int unsigned echo_wait;

    cmd_decoder #(
        .WDT_CYCLES   (WDT),
        .ECHO_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .data_received (data_received),
        .rx_done       (rx_done),
        .parity_error  (parity_error),
        .tx_busy       (tx_busy),
        .data_to_tx    (data_to_tx),
        .start_tx      (start_tx),
        .gate_en       (gate_en),
        .wdt_trip      (wdt_trip),
        .cmd_err       (cmd_err),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        check("gate_en",    8'(gate_en),  8'(m_gate));
        check("wdt_trip",   8'(wdt_trip), 8'(m_trip));
        check("start_tx",   8'(start_tx), 8'(m_start));
        check("cmd_err",    8'(cmd_err),  8'(m_err));
        check("data_to_tx", data_to_tx,   m_data);
        check("err_count",  err_count,    8'(m_errcnt));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_gate"},  8'(gate_en),  8'h00);
        check({tag, "_start"}, 8'(start_tx), 8'h00);
        check({tag, "_data"},  data_to_tx,   8'h00);
        check({tag, "_trip"},  8'(wdt_trip), 8'h00);
        check({tag, "_err"},   8'(cmd_err),  8'h00);
        check({tag, "_ecnt"},  err_count,    8'h00);
    endtask

    task automatic model_reset();
        m_gate = 0; m_trip = 0; m_start = 0; m_err = 0; m_errcnt = 0;
        m_data = 8'h00; on_cycles = 0; echo_mode = 0; echo_wait = 0;
    endtask

    // One clock of the reference behaviour, from the current inputs
    task automatic model_step(input bit rx, input logic [7:0] d, input bit par, input bit busy);
        bit acc, err;
        acc = rx && !par && (d == 8'hEE || d == 8'h55 || d == 8'hC3);
        err = rx && !acc;
        if (acc) begin
            if (d == 8'hEE)      m_gate = 1;
            else if (d == 8'h55) m_gate = 0;
            else                 m_gate = (m_gate == 0) ? 1 : 0;
            m_trip = 0;
            on_cycles = 0;
        end else if (m_gate == 1) begin
            on_cycles++;
            if (on_cycles == WDT) begin
                m_gate = 0; m_trip = 1; on_cycles = 0;
            end
        end else begin
            on_cycles = 0;
        end
        case (echo_mode)
            0: if (acc) begin
                echo_mode = 1; echo_wait = 0; m_start = 1; m_data = d;
            end
            1: begin
                if (acc) err = 1;
                if (busy) begin
                    m_start = 0; echo_mode = 2;
                end else begin
                    echo_wait++;
                    if (echo_wait == TO) begin
                        m_start = 0; err = 1; echo_mode = 0;
                    end
                end
            end
            default: begin
                if (acc) err = 1;
                if (!busy) echo_mode = 0;
            end
        endcase
        m_err = err ? 1 : 0;
        if (err && m_errcnt < 255) m_errcnt++;
    endtask

    // Drive one cycle from a negedge, advance model, check at the next negedge
    task automatic cycle(input bit rx, input logic [7:0] d, input bit par, input bit busy);
        rx_done = rx; data_received = d; parity_error = par; tx_busy = busy;
        model_step(rx, d, par, busy);
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic idle(input int n, input bit busy);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, busy);
    endtask

    // Asynchronous reset between edges, checked before any clock edge
    task automatic apply_reset(input string tag);
        rx_done = 1'b0; parity_error = 1'b0; tx_busy = 1'b0; data_received = 8'h00;
        #2 reset = 1'b0;
        #1 check_reset_values(tag);
        @(posedge clk);
        @(negedge clk);
        check_reset_values({tag, "_held"});
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [7:0] rd;
        model_reset();
        @(negedge clk);
        apply_reset("por");

        // Turn on and full echo handshake
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        check("on_gate", 8'(gate_en), 8'h01);
        check("on_start", 8'(start_tx), 8'h01);
        check("on_data", data_to_tx, 8'hEE);
        idle(2, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("on_start_drop", 8'(start_tx), 8'h00);
        idle(9, 1'b1);
        idle(1, 1'b0);

        // Two toggles, both echoed
        cycle(1'b1, 8'hC3, 1'b0, 1'b0);
        check("tog1_gate", 8'(gate_en), 8'h00);
        idle(4, 1'b1);
        idle(1, 1'b0);
        cycle(1'b1, 8'hC3, 1'b0, 1'b0);
        check("tog2_gate", 8'(gate_en), 8'h01);
        check("tog2_start", 8'(start_tx), 8'h01);
        check("tog2_data", data_to_tx, 8'hC3);
        idle(3, 1'b1);
        idle(1, 1'b0);

        // Rejections: parity error on a valid code, then unknown code
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        check("par_err", 8'(cmd_err), 8'h01);
        check("par_gate", 8'(gate_en), 8'h01);
        check("par_start", 8'(start_tx), 8'h00);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        check("unk_err", 8'(cmd_err), 8'h01);
        check("unk_ecnt", err_count, 8'h02);
        idle(1, 1'b0);

        // Watchdog: off, then on and silence for WDT cycles
        cycle(1'b1, 8'h55, 1'b0, 1'b0);
        idle(2, 1'b1);
        idle(1, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        idle(2, 1'b1);
        idle(int'(WDT) - 3, 1'b0);
        check("wdt_pre_gate", 8'(gate_en), 8'h01);
        check("wdt_pre_trip", 8'(wdt_trip), 8'h00);
        idle(1, 1'b0);
        check("wdt_gate", 8'(gate_en), 8'h00);
        check("wdt_trip", 8'(wdt_trip), 8'h01);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        check("wdt_clear", 8'(wdt_trip), 8'h00);
        idle(2, 1'b1);
        idle(1, 1'b0);

        // Echo timeout with a dropped echo in the middle
        cycle(1'b1, 8'h55, 1'b0, 1'b0);
        idle(4, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        check("drop_gate", 8'(gate_en), 8'h01);
        check("drop_err", 8'(cmd_err), 8'h01);
        check("drop_data", data_to_tx, 8'h55);
        idle(10, 1'b0);
        check("to_pre_start", 8'(start_tx), 8'h01);
        idle(1, 1'b0);
        check("to_start", 8'(start_tx), 8'h00);
        check("to_err", 8'(cmd_err), 8'h01);
        check("to_ecnt", err_count, 8'h04);

        // Reset in the middle of a request
        cycle(1'b1, 8'hC3, 1'b0, 1'b0);
        idle(2, 1'b0);
        apply_reset("midreq");

        // Error counter saturation
        for (int i = 0; i < 300; i++) begin
            rd = 8'($urandom_range(0, 255));
            if (rd == 8'hEE || rd == 8'h55 || rd == 8'hC3) rd = 8'h00;
            if (i % 2 == 0) cycle(1'b1, 8'hEE, 1'b1, 1'b0);
            else            cycle(1'b1, rd, 1'b0, 1'b0);
        end
        check("sat_ecnt", err_count, 8'hFF);
        apply_reset("pre_rand");

        // Random traffic: dense then sparse command rate
        begin
            bit busy_r = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                bit          rx;
                bit          par;
                logic [7:0]  d;
                int unsigned rate;
                rate = (i < 1500) ? 4 : 80;
                rx   = ($urandom_range(0, rate - 1) == 0);
                par  = ($urandom_range(0, 7) == 0);
                case ($urandom_range(0, 3))
                    0:       d = 8'hEE;
                    1:       d = 8'h55;
                    2:       d = 8'hC3;
                    default: d = 8'($urandom_range(0, 255));
                endcase
                if ($urandom_range(0, 7) == 0) busy_r = ~busy_r;
                cycle(rx, d, par, busy_r);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
